// File: rtl/subleq_core.sv
`default_nettype none
// ============================================================================
//  Module   : subleq_core
//  Summary  : SUBLEQ execution engine mastering an 8x256 1R/1W RAM.
//             mem[B] <= mem[B] - mem[A]; branch to C when the result is <= 0.
//             Optional retired-instruction counter: define SUBLEQ_ICNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module subleq_core #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [7:0]  ram_radr,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  ram_wadr,
    output logic [7:0]  ram_wdata,
    output logic        ram_wen,
    output logic        halted,
`ifdef SUBLEQ_ICNT_EN
    output logic [15:0] icnt,
`endif
    output logic [7:0]  pc
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GET_A  = 3'd1,
        S_GET_B  = 3'd2,
        S_GET_C  = 3'd3,
        S_GET_VA = 3'd4,
        S_EXEC   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [7:0] c_pc_step = 8'd3;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_pc;
    logic [7:0] r_a_adr;
    logic [7:0] r_b_adr;
    logic [7:0] r_c_adr;
    logic [7:0] r_a_val;
    logic       r_halted;

    logic [7:0] w_res;
    logic       w_le;
    logic [7:0] w_npc;
    logic       w_halt_hit;

    // Sign test is on the wrapped 8-bit result only; no overflow correction.
    assign w_res      = ram_rdata - r_a_val;
    assign w_le       = (w_res == 8'h00) || w_res[7];
    assign w_npc      = w_le ? r_c_adr : (r_pc + c_pc_step);
    assign w_halt_hit = w_le && (r_c_adr == r_pc);

    assign pc     = r_pc;
    assign halted = r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ram_radr    = r_pc;
        ram_wen     = 1'b0;
        ram_wadr    = 8'h00;
        ram_wdata   = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (run && !r_halted) begin
                    w_state_nxt = S_GET_A;
                end
            end
            S_GET_A: begin
                ram_radr    = r_pc + 8'd1;
                w_state_nxt = S_GET_B;
            end
            S_GET_B: begin
                ram_radr    = r_pc + 8'd2;
                w_state_nxt = S_GET_C;
            end
            S_GET_C: begin
                ram_radr    = r_a_adr;
                w_state_nxt = S_GET_VA;
            end
            S_GET_VA: begin
                ram_radr    = r_b_adr;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                // Next fetch address goes out with the write; the RAM forwards
                // the new data if the instruction rewrote its successor.
                ram_wen   = 1'b1;
                ram_wadr  = r_b_adr;
                ram_wdata = w_res;
                ram_radr  = w_npc;
                if (w_halt_hit) begin
                    w_state_nxt = S_HALT;
                end else if (run) begin
                    w_state_nxt = S_GET_A;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_a_adr  <= 8'h00;
            r_b_adr  <= 8'h00;
            r_c_adr  <= 8'h00;
            r_a_val  <= 8'h00;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_GET_A:  r_a_adr <= ram_rdata;
                S_GET_B:  r_b_adr <= ram_rdata;
                S_GET_C:  r_c_adr <= ram_rdata;
                S_GET_VA: r_a_val <= ram_rdata;
                S_EXEC: begin
                    r_pc <= w_npc;
                    if (w_halt_hit) begin
                        r_halted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SUBLEQ_ICNT_EN
    localparam logic [15:0] c_icnt_max = 16'hFFFF;

    logic [15:0] r_icnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_icnt <= 16'h0000;
        end else if ((r_state == S_EXEC) && (r_icnt != c_icnt_max)) begin
            r_icnt <= r_icnt + 16'd1;
        end
    end

    assign icnt = r_icnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_subleq_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_subleq_core
//  Summary  : Scoreboard bench for subleq_core with behavioural 1R/1W RAMs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_subleq_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic run1  = 1'b0;
    logic run2  = 1'b0;

    logic [7:0] radr1, rdata1, wadr1, wdata1, pc1;
    logic       wen1, halted1;
    logic [7:0] radr2, rdata2, wadr2, wdata2, pc2;
    logic       wen2, halted2;
`ifdef SUBLEQ_ICNT_EN
    logic [15:0] icnt1, icnt2;
`endif

    subleq_core #(.RESET_PC(8'h00)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .run(run1),
        .ram_radr(radr1), .ram_rdata(rdata1),
        .ram_wadr(wadr1), .ram_wdata(wdata1), .ram_wen(wen1),
        .halted(halted1),
`ifdef SUBLEQ_ICNT_EN
        .icnt(icnt1),
`endif
        .pc(pc1)
    );

    subleq_core #(.RESET_PC(8'hFD)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .run(run2),
        .ram_radr(radr2), .ram_rdata(rdata2),
        .ram_wadr(wadr2), .ram_wdata(wdata2), .ram_wen(wen2),
        .halted(halted2),
`ifdef SUBLEQ_ICNT_EN
        .icnt(icnt2),
`endif
        .pc(pc2)
    );

    // RAM models with write-then-read forwarding; loader ports used only in reset.
    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    logic       ld1 = 1'b0, ld2 = 1'b0, clr1 = 1'b0, clr2 = 1'b0;
    logic [7:0] ld_adr = 8'h00, ld_dat = 8'h00;

    always @(posedge clk) begin
        if (clr1) for (int i = 0; i < 256; i++) mem1[i] <= 8'h00;
        else if (ld1) mem1[ld_adr] <= ld_dat;
        else if (wen1) mem1[wadr1] <= wdata1;
        rdata1 <= (wen1 && (wadr1 == radr1)) ? wdata1 : mem1[radr1];
    end

    always @(posedge clk) begin
        if (clr2) for (int i = 0; i < 256; i++) mem2[i] <= 8'h00;
        else if (ld2) mem2[ld_adr] <= ld_dat;
        else if (wen2) mem2[wadr2] <= wdata2;
        rdata2 <= (wen2 && (wadr2 == radr2)) ? wdata2 : mem2[radr2];
    end

    int n_pass  = 0;
    int n_total = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endfunction

    typedef struct packed {
        logic [7:0] adr;
        logic [7:0] dat;
    } wr_t;

    wr_t q1[$];
    wr_t q2[$];

    always @(negedge clk) begin
        if (rst_n && wen1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_total++;
                $display("FAIL dut1_write: unexpected write adr=%0h data=%0h", wadr1, wdata1);
            end else begin
                wr_t e;
                e = q1.pop_front();
                chk("dut1_wadr", {24'h0, wadr1}, {24'h0, e.adr});
                chk("dut1_wdata", {24'h0, wdata1}, {24'h0, e.dat});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && wen2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_total++;
                $display("FAIL dut2_write: unexpected write adr=%0h data=%0h", wadr2, wdata2);
            end else begin
                wr_t e;
                e = q2.pop_front();
                chk("dut2_wadr", {24'h0, wadr2}, {24'h0, e.adr});
                chk("dut2_wdata", {24'h0, wdata2}, {24'h0, e.dat});
            end
        end
    end

    task automatic ram_clear(input bit which);
        @(negedge clk);
        if (which) clr2 = 1'b1; else clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        clr2 = 1'b0;
    endtask

    task automatic ram_load(input bit which, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_adr = a;
        ld_dat = d;
        if (which) ld2 = 1'b1; else ld1 = 1'b1;
        @(negedge clk);
        ld1 = 1'b0;
        ld2 = 1'b0;
    endtask

    task automatic load_prog1(input logic [7:0] m3, input logic [7:0] m4);
        rst_n = 1'b0;
        run1  = 1'b0;
        run2  = 1'b0;
        ram_clear(1'b0);
        ram_load(1'b0, 8'd0, 8'd3);
        ram_load(1'b0, 8'd1, 8'd4);
        ram_load(1'b0, 8'd2, 8'd9);
        ram_load(1'b0, 8'd3, m3);
        ram_load(1'b0, 8'd4, m4);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One instruction with run pulsed for one cycle; checks write timing and pc.
    task automatic run_one(input string nm, input logic [7:0] exp_pc);
        int  cyc;
        bit  seen;
        cyc  = 0;
        seen = 0;
        run1 = 1'b1;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) run1 = 1'b0;
            if (wen1 === 1'b1) seen = 1;
        end
        chk({nm, "_write_cycle"}, cyc, 5);
        @(negedge clk);
        chk({nm, "_pc"}, {24'h0, pc1}, {24'h0, exp_pc});
        chk({nm, "_idle_radr"}, {24'h0, radr1}, {24'h0, exp_pc});
        chk({nm, "_wen_after"}, {31'h0, wen1}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int         cyc;
        int         nwr;
        int         second_cyc;
        logic [7:0] exp_r [6];

        // Positive result, plus reset-state outputs.
        load_prog1(8'd5, 8'd7);
        chk("reset_radr", {24'h0, radr1}, 32'h00);
        chk("reset_wen", {31'h0, wen1}, 32'd0);
        chk("reset_wadr", {24'h0, wadr1}, 32'h00);
        chk("reset_wdata", {24'h0, wdata1}, 32'h00);
        chk("reset_pc", {24'h0, pc1}, 32'h00);
        chk("reset_halted", {31'h0, halted1}, 32'd0);
        chk("reset_radr_dut2", {24'h0, radr2}, 32'hFD);
        release_reset();
        q1.push_back('{adr: 8'h04, dat: 8'h02});
        run_one("positive", 8'h03);
        chk("positive_mem4", {24'h0, mem1[4]}, 32'h02);

        // Zero result branches.
        load_prog1(8'd5, 8'd5);
        release_reset();
        q1.push_back('{adr: 8'h04, dat: 8'h00});
        run_one("zero", 8'h09);

        // Negative wrap branches.
        load_prog1(8'd9, 8'd5);
        release_reset();
        q1.push_back('{adr: 8'h04, dat: 8'hFC});
        run_one("negative", 8'h09);

        // Branch to 9, then a self-loop at 9 that halts.
        load_prog1(8'd5, 8'd5);
        ram_load(1'b0, 8'd9, 8'd10);
        ram_load(1'b0, 8'd10, 8'd10);
        ram_load(1'b0, 8'd11, 8'd9);
        release_reset();
        q1.push_back('{adr: 8'h04, dat: 8'h00});
        q1.push_back('{adr: 8'h0A, dat: 8'h00});
        run1       = 1'b1;
        cyc        = 0;
        nwr        = 0;
        second_cyc = 0;
        while (nwr < 2 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (wen1 === 1'b1) begin
                nwr++;
                if (nwr == 2) second_cyc = cyc;
            end
        end
        chk("halt_write_cycle", second_cyc, 10);
        @(negedge clk);
        chk("halt_halted", {31'h0, halted1}, 32'd1);
        chk("halt_pc", {24'h0, pc1}, 32'h09);
        nwr = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wen1 !== 1'b0) nwr++;
        end
        chk("halt_no_more_writes", nwr, 0);
        chk("halt_radr", {24'h0, radr1}, 32'h09);
        chk("halt_sticky", {31'h0, halted1}, 32'd1);
        run1 = 1'b0;

        // Address wrap at the top of memory, run dropped during GET_B.
        rst_n = 1'b0;
        ram_clear(1'b1);
        ram_load(1'b1, 8'hFD, 8'h00);
        ram_load(1'b1, 8'hFE, 8'h01);
        ram_load(1'b1, 8'hFF, 8'h00);
        ram_load(1'b1, 8'h00, 8'h01);
        ram_load(1'b1, 8'h01, 8'h09);
        chk("wrap_reset_pc", {24'h0, pc2}, 32'hFD);
        release_reset();
        chk("wrap_radr_idle", {24'h0, radr2}, 32'hFD);
        q2.push_back('{adr: 8'h01, dat: 8'h08});
        exp_r[0] = 8'hFE;
        exp_r[1] = 8'hFF;
        exp_r[2] = 8'h00;
        exp_r[3] = 8'h01;
        exp_r[4] = 8'h00;
        exp_r[5] = 8'h00;
        run2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) run2 = 1'b0;
            chk($sformatf("wrap_radr_c%0d", i + 1), {24'h0, radr2}, {24'h0, exp_r[i]});
        end
        chk("wrap_pc", {24'h0, pc2}, 32'h00);
        chk("wrap_idle_wen", {31'h0, wen2}, 32'd0);
        chk("wrap_mem1", {24'h0, mem2[1]}, 32'h08);

        // Reset during EXEC discards the write.
        load_prog1(8'd5, 8'd7);
        release_reset();
        run1 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rexec_wen_before", {31'h0, wen1}, 32'd1);
        rst_n = 1'b0;
        run1  = 1'b0;
        #1;
        chk("rexec_wen_now", {31'h0, wen1}, 32'd0);
        chk("rexec_pc", {24'h0, pc1}, 32'h00);
        chk("rexec_halted", {31'h0, halted1}, 32'd0);
        repeat (2) @(negedge clk);
        chk("rexec_mem4", {24'h0, mem1[4]}, 32'h07);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("dut1_pending_writes", q1.size(), 0);
        chk("dut2_pending_writes", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
